final_project_soc_onchip_memory_arb: RTL and testbench

Parametrised on-chip RAM for the final-project SoC, replacing the fixed 4×32 single-port memory. It presents two Avalon-MM slave ports, s1 and s2, onto one single-port byte-enabled array. A round-robin arbiter drives per-port waitrequest. A pipelined read path drives per-port readdatavalid. It sits behind the interconnect and serves, for example, the CPU data master on s1 and a DMA/VGA master on s2.

---
 rtl/final_project_soc_mem_pkg.sv | 17 +
 rtl/final_project_soc_onchip_ram_core.sv | 32 +++
 rtl/final_project_soc_onchip_memory_arb.sv | 144 ++++++++++++++
 tb/tb_final_project_soc_onchip_memory_arb.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/final_project_soc_mem_pkg.sv
// Shared types and constants for the dual-port arbitrated on-chip memory.
package final_project_soc_mem_pkg;

    typedef enum logic {
        PORT_S1 = 1'b0,
        PORT_S2 = 1'b1
    } port_e;

    typedef struct packed {
        logic  valid;
        port_e port;
    } read_tag_t;

    localparam int unsigned READ_LATENCY_MIN = 1;
    localparam int unsigned READ_LATENCY_MAX = 2;

endpackage

// File: rtl/final_project_soc_onchip_ram_core.sv
// Single-port byte-enabled RAM with a once-registered read port (read-first on writes).
module final_project_soc_onchip_ram_core #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter string       INIT_FILE  = ""
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   q
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < LANES; b++) begin
                    if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/final_project_soc_onchip_memory_arb.sv
// Two Avalon-MM slave ports round-robin arbitrated onto one byte-enabled RAM,
// with a tagged read pipeline routing readdatavalid back to the requesting port.
module final_project_soc_onchip_memory_arb
    import final_project_soc_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned READ_LATENCY = 1,
    parameter string       INIT_FILE    = "final_project_soc_onchip_memory_arb.hex"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clken,
    input  logic                    reset_req,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic                    s1_waitrequest,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic                    s2_waitrequest,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid
);

    logic live, req1, req2, grant1, grant2;
    port_e last_grant_q, last_grant_d;

    logic                    ram_en, ram_we;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [DATA_WIDTH/8-1:0] ram_be;
    logic [DATA_WIDTH-1:0]   ram_wdata, ram_q, out_data;

    read_tag_t new_tag, head;
    read_tag_t tag_q [READ_LATENCY];
    logic pulse1, pulse2;
    logic [DATA_WIDTH-1:0] rdata1_d, rdata1_q, rdata2_d, rdata2_q;

    // Reset also blocks grants so waitrequest mirrors the request during reset.
    assign live = clken & ~reset_req & ~reset;
    assign req1 = s1_chipselect & (s1_read | s1_write);
    assign req2 = s2_chipselect & (s2_read | s2_write);

    always_comb begin
        grant1       = 1'b0;
        grant2       = 1'b0;
        last_grant_d = last_grant_q;
        if (live) begin
            grant1 = req1 & (~req2 | (last_grant_q == PORT_S2));
            grant2 = req2 & (~req1 | (last_grant_q == PORT_S1));
        end
        if (grant1) last_grant_d = PORT_S1;
        if (grant2) last_grant_d = PORT_S2;
    end

    assign s1_waitrequest = req1 & ~grant1;
    assign s2_waitrequest = req2 & ~grant2;

    always_comb begin
        ram_en        = grant1 | grant2;
        ram_we        = grant2 ? s2_write      : s1_write;
        ram_addr      = grant2 ? s2_address    : s1_address;
        ram_be        = grant2 ? s2_byteenable : s1_byteenable;
        ram_wdata     = grant2 ? s2_writedata  : s1_writedata;
        new_tag.valid = ram_en & ~ram_we;
        new_tag.port  = grant2 ? PORT_S2 : PORT_S1;
    end

    final_project_soc_onchip_ram_core #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .be   (ram_be),
        .wdata(ram_wdata),
        .q    (ram_q)
    );

    // Tag pipeline and arbiter state only advance on live cycles, so stalls hold them.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_q[i] <= '{valid: 1'b0, port: PORT_S1};
            end
            last_grant_q <= PORT_S2;
        end else if (live) begin
            tag_q[0] <= new_tag;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            last_grant_q <= last_grant_d;
        end
    end

    if (READ_LATENCY >= READ_LATENCY_MAX) begin : g_out_reg
        logic [DATA_WIDTH-1:0] out_q;
        always_ff @(posedge clk) begin
            if (live) out_q <= ram_q;
        end
        assign out_data = out_q;
    end else begin : g_no_out_reg
        assign out_data = ram_q;
    end

    assign head   = tag_q[READ_LATENCY-1];
    assign pulse1 = live & head.valid & (head.port == PORT_S1);
    assign pulse2 = live & head.valid & (head.port == PORT_S2);

    // Each port keeps its last delivered word; reset forces zero immediately.
    always_comb begin
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        if (pulse1) rdata1_d = out_data;
        if (pulse2) rdata2_d = out_data;
        if (reset) begin
            rdata1_d = '0;
            rdata2_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        rdata1_q <= rdata1_d;
        rdata2_q <= rdata2_d;
    end

    assign s1_readdata      = rdata1_d;
    assign s2_readdata      = rdata2_d;
    assign s1_readdatavalid = pulse1;
    assign s2_readdatavalid = pulse2;

endmodule

// File: tb/tb_final_project_soc_onchip_memory_arb.sv
// Bench: READ_LATENCY 1 and 2 instances share stimulus; a queue-based model checks every cycle.
module tb_final_project_soc_onchip_memory_arb;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;

    logic clk = 1'b0;
    logic rst, clken, reset_req;
    logic [2:1] cs, rd, wr;
    logic [AW-1:0] addr [1:2];
    logic [3:0]    be   [1:2];
    logic [31:0]   wd   [1:2];
    logic [2:1] wait_a, rdv_a, wait_b, rdv_b;
    logic [31:0] rdata_a [1:2];
    logic [31:0] rdata_b [1:2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    final_project_soc_onchip_memory_arb #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .INIT_FILE("")
    ) dut_a (
        .clk(clk), .reset(rst), .clken(clken), .reset_req(reset_req),
        .s1_address(addr[1]), .s1_chipselect(cs[1]), .s1_read(rd[1]), .s1_write(wr[1]),
        .s1_byteenable(be[1]), .s1_writedata(wd[1]), .s1_waitrequest(wait_a[1]),
        .s1_readdata(rdata_a[1]), .s1_readdatavalid(rdv_a[1]),
        .s2_address(addr[2]), .s2_chipselect(cs[2]), .s2_read(rd[2]), .s2_write(wr[2]),
        .s2_byteenable(be[2]), .s2_writedata(wd[2]), .s2_waitrequest(wait_a[2]),
        .s2_readdata(rdata_a[2]), .s2_readdatavalid(rdv_a[2])
    );

    final_project_soc_onchip_memory_arb #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .INIT_FILE("")
    ) dut_b (
        .clk(clk), .reset(rst), .clken(clken), .reset_req(reset_req),
        .s1_address(addr[1]), .s1_chipselect(cs[1]), .s1_read(rd[1]), .s1_write(wr[1]),
        .s1_byteenable(be[1]), .s1_writedata(wd[1]), .s1_waitrequest(wait_b[1]),
        .s1_readdata(rdata_b[1]), .s1_readdatavalid(rdv_b[1]),
        .s2_address(addr[2]), .s2_chipselect(cs[2]), .s2_read(rd[2]), .s2_write(wr[2]),
        .s2_byteenable(be[2]), .s2_writedata(wd[2]), .s2_waitrequest(wait_b[2]),
        .s2_readdata(rdata_b[2]), .s2_readdatavalid(rdv_b[2])
    );

    task automatic cmp(input string name, input int inst, input int port,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s rl%0d s%0d @%0t: got %h expected %h", name, inst, port, $time,
                     act, exp);
        end
    endtask

    // Model: reads are remembered with the live-cycle index of their grant and
    // delivered on live cycle (grant index + latency).
    typedef struct {
        int          port;
        logic [31:0] data;
        int          g;
    } rd_t;

    rd_t         pq[$];
    logic [31:0] m_mem  [16];
    logic [31:0] m_hold [0:1][1:2];
    int          lc     = 0;
    int          m_last = 2;

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_hold[k][1] = '0;
            m_hold[k][2] = '0;
        end
    end

    always @(negedge clk) begin
        bit          live;
        logic [2:1]  req, gnt, ev;
        logic [31:0] ed [1:2];
        logic [31:0] exp_rd;
        int          gp;
        rd_t         e;

        live = clken && !reset_req && !rst;
        for (int p = 1; p <= 2; p++) req[p] = cs[p] && (rd[p] || wr[p]);
        gnt = '0;
        if (live) begin
            if (req == 2'b11) gnt = (m_last == 2) ? 2'b01 : 2'b10;
            else gnt = req;
        end
        if (live) lc++;

        for (int p = 1; p <= 2; p++) begin
            cmp("waitrequest", 1, p, {31'd0, wait_a[p]}, {31'd0, req[p] && !gnt[p]});
            cmp("waitrequest", 2, p, {31'd0, wait_b[p]}, {31'd0, req[p] && !gnt[p]});
        end

        for (int k = 0; k < 2; k++) begin
            ev = '0;
            ed[1] = '0;
            ed[2] = '0;
            if (live) begin
                foreach (pq[i]) begin
                    if (pq[i].g + k + 1 == lc) begin
                        ev[pq[i].port] = 1'b1;
                        ed[pq[i].port] = pq[i].data;
                    end
                end
            end
            for (int p = 1; p <= 2; p++) begin
                exp_rd = rst ? 32'd0 : (ev[p] ? ed[p] : m_hold[k][p]);
                cmp("readdatavalid", k + 1, p,
                    {31'd0, (k == 0) ? rdv_a[p] : rdv_b[p]}, {31'd0, ev[p]});
                cmp("readdata", k + 1, p, (k == 0) ? rdata_a[p] : rdata_b[p], exp_rd);
                m_hold[k][p] = exp_rd;
            end
        end

        if (rst) begin
            pq.delete();
            m_last = 2;
        end else if (gnt != 2'b00) begin
            gp = gnt[1] ? 1 : 2;
            if (wr[gp]) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[gp][b]) m_mem[addr[gp]][8*b +: 8] = wd[gp][8*b +: 8];
                end
            end else begin
                e.port = gp;
                e.data = m_mem[addr[gp]];
                e.g    = lc;
                pq.push_back(e);
            end
            m_last = gp;
        end
        while (pq.size() > 0 && pq[0].g + 2 <= lc) void'(pq.pop_front());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cs = '0;
        rd = '0;
        wr = '0;
        for (int p = 1; p <= 2; p++) begin
            addr[p] = '0;
            be[p]   = '0;
            wd[p]   = '0;
        end
    endtask

    task automatic drive(input int p, input bit r, input bit w, input int a,
                         input logic [3:0] b, input logic [31:0] d);
        idle();
        cs[p]   = 1'b1;
        rd[p]   = r;
        wr[p]   = w;
        addr[p] = a[AW-1:0];
        be[p]   = b;
        wd[p]   = d;
    endtask

    initial begin
        int n1, n2;
        rst       = 1'b1;
        clken     = 1'b1;
        reset_req = 1'b0;
        idle();
        tick();
        tick();

        // During reset: waitrequest follows the request, outputs are zero.
        drive(1, 1'b1, 1'b0, 0, 4'h0, 32'h0);
        @(negedge clk);
        cmp("rst_waitreq", 1, 1, {31'd0, wait_a[1]}, 32'd1);
        cmp("rst_rdv", 1, 1, {31'd0, rdv_a[1]}, 32'd0);
        cmp("rst_rdata", 2, 2, rdata_b[2], 32'd0);
        tick();
        idle();
        rst = 1'b0;

        for (int a = 0; a < 16; a++) begin
            drive(1, 1'b0, 1'b1, a, 4'hF, $urandom);
            tick();
        end

        // Full-word write then read on s1.
        drive(1, 1'b0, 1'b1, 5, 4'hF, 32'hDEADBEEF);
        tick();
        drive(1, 1'b1, 1'b0, 5, 4'h0, 32'h0);
        tick();
        idle();
        @(negedge clk);
        cmp("t1_rdv", 1, 1, {31'd0, rdv_a[1]}, 32'd1);
        cmp("t1_data", 1, 1, rdata_a[1], 32'hDEADBEEF);
        cmp("t1_other_rdv", 1, 2, {31'd0, rdv_a[2]}, 32'd0);
        tick();
        @(negedge clk);
        cmp("t1_rdv", 2, 1, {31'd0, rdv_b[1]}, 32'd1);
        cmp("t1_data", 2, 1, rdata_b[1], 32'hDEADBEEF);
        tick();

        // Partial byte-lane write on s2.
        drive(2, 1'b0, 1'b1, 7, 4'hF, 32'hAAAAAAAA);
        tick();
        drive(2, 1'b0, 1'b1, 7, 4'b0101, 32'h11223344);
        tick();
        drive(2, 1'b1, 1'b0, 7, 4'h0, 32'h0);
        tick();
        idle();
        @(negedge clk);
        cmp("t2_rdv", 1, 2, {31'd0, rdv_a[2]}, 32'd1);
        cmp("t2_data", 1, 2, rdata_a[2], 32'hAA22AA44);
        tick();
        @(negedge clk);
        cmp("t2_data", 2, 2, rdata_b[2], 32'hAA22AA44);
        tick();

        // Contention: both ports read every cycle; grants alternate starting with s1.
        n1 = 0;
        n2 = 0;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                cs = 2'b11;
                rd = 2'b11;
                wr = 2'b00;
                addr[1] = 4'(k);
                addr[2] = 4'(8 + k);
            end else begin
                idle();
            end
            @(negedge clk);
            if (k < 8) begin
                cmp("cont_wait", 1, 1, {31'd0, wait_a[1]}, 32'(k % 2));
                cmp("cont_wait", 1, 2, {31'd0, wait_a[2]}, 32'((k + 1) % 2));
            end
            n1 += int'(rdv_a[1]);
            n2 += int'(rdv_a[2]);
            tick();
        end
        cmp("cont_pulses", 1, 1, n1, 32'd4);
        cmp("cont_pulses", 1, 2, n2, 32'd4);

        // Stall: clken low for three cycles right after a read grant.
        drive(1, 1'b1, 1'b0, 5, 4'h0, 32'h0);
        tick();
        idle();
        clken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp("stall_rdv", 1, 1, {31'd0, rdv_a[1]}, 32'd0);
            cmp("stall_rdv", 2, 1, {31'd0, rdv_b[1]}, 32'd0);
            tick();
        end
        clken = 1'b1;
        @(negedge clk);
        cmp("stall_rdv_out", 1, 1, {31'd0, rdv_a[1]}, 32'd1);
        cmp("stall_rdv_early", 2, 1, {31'd0, rdv_b[1]}, 32'd0);
        tick();
        @(negedge clk);
        cmp("stall_rdv_out", 2, 1, {31'd0, rdv_b[1]}, 32'd1);
        cmp("stall_data", 2, 1, rdata_b[1], 32'hDEADBEEF);
        cmp("stall_rdv_once", 1, 1, {31'd0, rdv_a[1]}, 32'd0);
        tick();
        @(negedge clk);
        cmp("stall_rdv_once", 2, 1, {31'd0, rdv_b[1]}, 32'd0);
        tick();

        // Reset with a read in flight; the first tie afterwards goes to s1.
        drive(1, 1'b1, 1'b0, 5, 4'h0, 32'h0);
        tick();
        idle();
        rst = 1'b1;
        @(negedge clk);
        cmp("rstmid_rdv", 1, 1, {31'd0, rdv_a[1]}, 32'd0);
        cmp("rstmid_data", 1, 1, rdata_a[1], 32'd0);
        tick();
        rst = 1'b0;
        cs = 2'b11;
        rd = 2'b11;
        addr[1] = 4'd1;
        addr[2] = 4'd2;
        @(negedge clk);
        cmp("rstmid_tie", 1, 1, {31'd0, wait_a[1]}, 32'd0);
        cmp("rstmid_tie", 1, 2, {31'd0, wait_a[2]}, 32'd1);
        cmp("rstmid_rdv", 2, 1, {31'd0, rdv_b[1]}, 32'd0);
        cmp("rstmid_data", 1, 1, rdata_a[1], 32'd0);
        tick();
        idle();
        tick();
        tick();

        // Read and write together act as a write with no readdatavalid.
        drive(1, 1'b1, 1'b1, 3, 4'hF, 32'h5);
        tick();
        idle();
        @(negedge clk);
        cmp("rw_rdv", 1, 1, {31'd0, rdv_a[1]}, 32'd0);
        tick();
        @(negedge clk);
        cmp("rw_rdv", 2, 1, {31'd0, rdv_b[1]}, 32'd0);
        drive(1, 1'b1, 1'b0, 3, 4'h0, 32'h0);
        tick();
        idle();
        @(negedge clk);
        cmp("rw_data", 1, 1, rdata_a[1], 32'h5);
        tick();
        tick();

        // Random traffic with stalls and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            for (int p = 1; p <= 2; p++) begin
                cs[p]   = ($urandom_range(3) != 0);
                rd[p]   = 1'($urandom_range(1));
                wr[p]   = 1'($urandom_range(1));
                addr[p] = 4'($urandom_range(15));
                be[p]   = 4'($urandom_range(15));
                wd[p]   = $urandom;
            end
            clken     = ($urandom_range(9) != 0);
            reset_req = ($urandom_range(19) == 0);
            rst       = ($urandom_range(99) == 0);
            tick();
        end
        idle();
        rst       = 1'b0;
        clken     = 1'b1;
        reset_req = 1'b0;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
